// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the CPU data-RAM interface. Accepts one read or
// write request at a time, waits WAIT_STATES cycles, executes the access on the
// edge that enters the response cycle, and signals completion with a single
// ready pulse. Illegal requests (read and write together, or an address beyond
// the implemented depth) still complete with normal timing, but they raise err.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    // Index width is sized to the implemented depth, not to the address bus.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Counter reload value; with zero wait states the counter is never used.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Depth widened by one bit so it can be compared with any address value.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;

    logic                rd_r;
    logic                wr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;

    logic                ready_r;
    logic                busy_r;
    logic                err_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                accept_s;
    logic                exec_s;
    logic                op_read_s;
    logic                op_write_s;
    logic [ADDR_W-1:0]   op_addr_s;
    logic [DATA_W-1:0]   op_wdata_s;
    logic [IDX_W-1:0]    op_idx_s;
    logic                illegal_s;
    logic                in_range_s;
    logic                err_s;
    logic                mem_we_s;
    logic                rdata_load_s;
    logic [DATA_W-1:0]   rdata_next_s;

    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    // State and wait-counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; also flags the acceptance edge and the execute edge.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        exec_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ram_read || ram_write) begin
                    accept_s   = 1'b1;
                    cnt_next_s = WAIT_LOAD;
                    if (WAIT_STATES > 0) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        // No wait cycles: the access happens on the acceptance edge.
                        next_state_s = ST_RESP;
                        exec_s       = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                    exec_s       = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                // Request inputs are still held here and are deliberately ignored.
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Operation selection: live inputs when executing straight from IDLE,
    // latched copies otherwise. Also classifies the request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_read_s  = ram_read;
            op_write_s = ram_write;
            op_addr_s  = ram_addr;
            op_wdata_s = ram_wdata;
        end else begin
            op_read_s  = rd_r;
            op_write_s = wr_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
        op_idx_s     = op_addr_s[IDX_W-1:0];
        illegal_s    = op_read_s && op_write_s;
        in_range_s   = ({1'b0, op_addr_s} < DEPTH_C);
        err_s        = illegal_s || !in_range_s;
        // Reset gating keeps a write from landing while the block is held in reset.
        mem_we_s     = reset && exec_s && op_write_s && !op_read_s && in_range_s;
        rdata_load_s = exec_s && op_read_s && !op_write_s;
        if (in_range_s) begin
            rdata_next_s = mem_r[op_idx_s];
        end else begin
            // Out-of-range reads return zero; the address is never wrapped.
            rdata_next_s = {DATA_W{1'b0}};
        end
    end

    // Request latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                rd_r    <= ram_read;
                wr_r    <= ram_write;
                addr_r  <= ram_addr;
                wdata_r <= ram_wdata;
                busy_r  <= 1'b1;
            end else if (state_r == ST_RESP) begin
                busy_r  <= 1'b0;
            end else begin
                busy_r  <= busy_r;
            end

            if (exec_s) begin
                ready_r <= 1'b1;
                err_r   <= err_s;
            end else begin
                ready_r <= 1'b0;
                err_r   <= 1'b0;
            end

            if (rdata_load_s) begin
                rdata_r <= rdata_next_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Data RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end

    assign ram_rdata = rdata_r;
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule
